// File: rtl/rotating_square_mux.sv
// ============================================================================
// rotating_square_mux : rotating-square driver for an N-digit muxed 7-seg display
// Rev 1.0
// ============================================================================
`default_nettype none

module rotating_square_mux #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_CNT = 50000,
  parameter int STEP_CNT    = 12500000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            cw,
  output logic [N_DIGITS-1:0]             an,
  output logic [6:0]                      sseg,
  output logic [$clog2(2*N_DIGITS)-1:0]   pos
);

  localparam int POS_W  = $clog2(2*N_DIGITS);
  localparam int SCAN_W = $clog2(N_DIGITS);
  localparam int REF_W  = $clog2(REFRESH_CNT);
  localparam int STEP_W = $clog2(STEP_CNT);

  localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(2*N_DIGITS-1);
  localparam logic [POS_W-1:0]    POS_NDIG  = POS_W'(N_DIGITS);
  localparam logic [POS_W-1:0]    POS_TOPD  = POS_W'(N_DIGITS-1);
  localparam logic [SCAN_W-1:0]   SCAN_LAST = SCAN_W'(N_DIGITS-1);
  localparam logic [REF_W-1:0]    REF_LAST  = REF_W'(REFRESH_CNT-1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CNT-1);
  localparam logic [N_DIGITS-1:0] ONE_HOT   = N_DIGITS'(1);

  localparam logic [6:0] SEG_UPPER = 7'b0011100;
  localparam logic [6:0] SEG_LOWER = 7'b0100011;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic en_meta, en_s, cw_meta, cw_s;

  logic [STEP_W-1:0] step_cnt;
  logic [REF_W-1:0]  ref_cnt;
  logic [SCAN_W-1:0] scan;

  logic [POS_W-1:0]    pos_cw, pos_ccw, sq_digit;
  logic                upper;
  logic [N_DIGITS-1:0] an_next;
  logic [6:0]          sseg_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_meta <= 1'b0;
      en_s    <= 1'b0;
      cw_meta <= 1'b0;
      cw_s    <= 1'b0;
    end else begin
      en_meta <= en;
      en_s    <= en_meta;
      cw_meta <= cw;
      cw_s    <= cw_meta;
    end
  end

  // Step counter only advances while enabled, so a pause resumes mid-interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt <= '0;
      pos      <= '0;
    end else if (en_s) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        pos      <= cw_s ? pos_cw : pos_ccw;
      end else begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt <= '0;
      scan    <= '0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt <= '0;
      scan    <= (scan == SCAN_LAST) ? '0 : scan + SCAN_W'(1);
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  always_comb begin
    pos_cw  = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    pos_ccw = (pos == '0) ? POS_LAST : pos - POS_W'(1);
    upper   = (pos < POS_NDIG);
    // Upper squares run left to right, lower squares right to left.
    sq_digit = upper ? (POS_TOPD - pos) : (pos - POS_NDIG);
    an_next  = ~(ONE_HOT << scan);
    sseg_next = SEG_BLANK;
    if (sq_digit == {{(POS_W-SCAN_W){1'b0}}, scan}) begin
      sseg_next = upper ? SEG_UPPER : SEG_LOWER;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= '1;
      sseg <= SEG_BLANK;
    end else begin
      an   <= an_next;
      sseg <= sseg_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rotating_square_mux.sv
// ============================================================================
// tb_rotating_square_mux : directed bench, N_DIGITS=4, REFRESH_CNT=4, STEP_CNT=8
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rotating_square_mux;

  localparam logic [6:0] UP    = 7'b0011100;
  localparam logic [6:0] LO    = 7'b0100011;
  localparam logic [6:0] BLANK = 7'h7F;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic       cw    = 1'b0;
  logic [3:0] an;
  logic [6:0] sseg;
  logic [2:0] pos;

  int checks = 0;
  int errors = 0;
  int t      = 0;  // rising edges since the last reset release

  rotating_square_mux #(
    .N_DIGITS   (4),
    .REFRESH_CNT(4),
    .STEP_CNT   (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .cw   (cw),
    .an   (an),
    .sseg (sseg),
    .pos  (pos)
  );

  always #5 clk = ~clk;

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge that follows rising edge number k.
  task automatic go_to(input int k);
    while (t < k) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic restart(input logic en_v, input logic cw_v);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk4("reset_an", an, 4'b1111);
    chk7("reset_sseg", sseg, BLANK);
    chk3("reset_pos", pos, 3'd0);
    repeat (2) @(negedge clk);
    en    = en_v;
    cw    = cw_v;
    reset = 1'b0;
    t     = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] one;
    logic [3:0] exp_an;
    logic [6:0] exp_sseg;
    int         s;
    one = 4'b0001;

    // Clockwise sweep from reset; steps land on edges 10, 18, 26, ...
    restart(1'b1, 1'b1);
    go_to(1);
    chk4("first_an", an, 4'b1110);
    chk7("first_sseg", sseg, BLANK);
    chk3("first_pos", pos, 3'd0);
    for (int m = 0; m <= 8; m++) begin
      go_to(9 + 8*m);
      chk3("cw_before_step", pos, 3'(m % 8));
      go_to(10 + 8*m);
      chk3("cw_after_step", pos, 3'((m + 1) % 8));
      if (m == 1) begin
        go_to(22);
        chk4("cw_pos2_an", an, 4'b1101);
        chk7("cw_pos2_sseg", sseg, UP);
      end
      if (m == 4) begin
        go_to(46);
        chk4("cw_pos5_an", an, 4'b0111);
        chk7("cw_pos5_off_sseg", sseg, BLANK);
      end
    end
    go_to(75);

    // Counter-clockwise, then pause/resume; reset lands mid-run at pos 1.
    restart(1'b1, 1'b0);
    go_to(9);
    chk3("ccw_hold0", pos, 3'd0);
    go_to(10);
    chk3("ccw_wrap7", pos, 3'd7);
    go_to(14);
    chk4("ccw_pos7_an", an, 4'b0111);
    chk7("ccw_pos7_sseg", sseg, LO);
    go_to(17);
    chk3("ccw_hold7", pos, 3'd7);
    go_to(18);
    chk3("ccw_step6", pos, 3'd6);
    go_to(21);
    en = 1'b0;              // five counts taken (edges 19..23) before en_s drops
    go_to(26);
    chk3("pause_no_step", pos, 3'd6);
    go_to(41);
    chk3("pause_hold", pos, 3'd6);
    en = 1'b1;              // en_s high after edge 43
    go_to(45);
    chk3("resume_pre", pos, 3'd6);
    go_to(46);
    chk3("resume_step", pos, 3'd5);
    go_to(50);
    chk4("pos5_scan0_an", an, 4'b1110);
    chk7("pos5_scan0_sseg", sseg, BLANK);
    go_to(53);
    chk4("pos5_scan1_an", an, 4'b1101);
    chk7("pos5_scan1_sseg", sseg, LO);

    // Full scan frame with the square parked at pos 2.
    restart(1'b1, 1'b1);
    go_to(18);
    chk3("scan_park_pos", pos, 3'd2);
    en = 1'b0;
    for (int k = 21; k <= 36; k++) begin
      go_to(k);
      s        = ((k - 1) / 4) % 4;
      exp_an   = ~(one << s);
      exp_sseg = (s == 1) ? UP : BLANK;
      chk4("scan_an", an, exp_an);
      chk7("scan_sseg", sseg, exp_sseg);
    end
    chk3("scan_pos_held", pos, 3'd2);

    // Direction flips: early flip takes effect, late flip misses the step.
    restart(1'b1, 1'b1);
    go_to(10);
    chk3("dir_first", pos, 3'd1);
    go_to(12);
    cw = 1'b0;
    go_to(18);
    chk3("dir_flip_ccw", pos, 3'd0);
    go_to(24);
    cw = 1'b1;
    go_to(26);
    chk3("dir_late_flip", pos, 3'd7);
    go_to(34);
    chk3("dir_flip_cw", pos, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rotating_square_mux.md
# rotating_square_mux

Parametrised rotating-square display driver for an N-digit, time-multiplexed seven-segment display. A square travels around a closed loop: upper squares across the top of the digits, lower squares back along the bottom. Rotation rate and refresh rate come from internal clock-enable counters, so the block runs entirely on the board clock with no divided clock and no BUFG. It replaces the divider-plus-rotator pair at board top level and adds digit-count generalisation, pause-with-resume and a position readback.

## Interface
- N_DIGITS, 4, number of display digits; legal 2..8.
- REFRESH_CNT, 50000, clk cycles per digit scan slot; legal ≥2.
- STEP_CNT, 12500000, clk cycles of enabled time per rotation step; legal ≥2.
- clk  input  1  board clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  rotation enable (raw switch, asynchronous to clk).
- cw  input  1  direction: 1 = clockwise, 0 = counter-clockwise (raw switch).
- an  output  N_DIGITS  digit enables, active-low; an[0] = rightmost digit.
- sseg  output  7  segments, active-low; sseg[0]=a … sseg[6]=g.
- pos  output  clog2(2*N_DIGITS)  current square position, for verification.

## Operation
- Synchroniser: en and cw each pass through a 2-flop synchroniser (en_s, cw_s). Only synchronised values are used internally.
- Position loop: pos ranges 0..2N-1.
  - p < N: upper square (segments a,b,f,g; sseg = 7'b0011100) on digit N-1-p, so p=0 is the leftmost digit.
  - p ≥ N: lower square (segments c,d,e,g; sseg = 7'b0100011) on digit p-N, so p=N is the rightmost digit.
- Step counter: increments only on cycles with en_s=1, holding its value when en_s=0. Pause therefore resumes mid-interval rather than restarting.
  - On an en_s=1 cycle with the count = STEP_CNT-1, the count wraps to 0 and pos steps.
  - cw_s=1: pos = (pos+1) mod 2N. cw_s=0: pos = (pos-1) mod 2N. 0 wraps to 2N-1; 2N-1 wraps to 0.
  - Direction is sampled on the step cycle only.
- Refresh: the refresh counter runs freely 0..REFRESH_CNT-1. On wrap, scan = (scan+1) mod N.
- Output register, loaded every cycle:
  - an = all ones except bit scan = 0.
  - sseg = square pattern if the square's digit equals scan, else 7'h7F.
  - The square never appears on more than one digit.
- Counter widths: clog2 of the respective count. No arithmetic overflow is permitted; compare-and-wrap only.
- Reset values: pos=0, scan=0, both counters 0, synchronisers 0, an = all ones, sseg = 7'h7F.
- Reset asserted mid-operation clears all state immediately (asynchronous), blanking the display.

## Timing
- en/cw latency: a switch change affects the counter 2 clk edges after it is sampled.
- Step: pos changes on the edge where the count = STEP_CNT-1 and en_s=1. an/sseg reflect the new pos one edge later.
- First edge after reset release: an = ~(1<<0) = 4'b1110 (N=4). sseg follows the digit-0 match.
- Scan slot length: exactly REFRESH_CNT cycles per digit, N*REFRESH_CNT per frame.
- Simultaneous step and scan advance on the same edge: both take effect. The output register uses the updated pos and scan on the following edge.
- en_s falling on the same cycle the count = STEP_CNT-1: no step, count holds at STEP_CNT-1. The step fires on the first en_s=1 cycle after resume.

## Test plan
All scenarios use N_DIGITS=4, REFRESH_CNT=4, STEP_CNT=8.
- Reset: assert reset mid-run → an=4'b1111, sseg=7'h7F, pos=0 immediately. First edge after release → an=4'b1110, sseg=7'h7F.
- Clockwise sweep: en=cw=1 held → pos steps every 8 cycles through 0,1,…,7, then wraps to 0. Pos 2 displays 7'b0011100 on an=4'b1101; pos 5 displays 7'b0100011 on an=4'b1101.
- Counter-clockwise: cw=0 from pos=0 → next pos=7, then 6. Pos 7 displays 7'b0100011 on an=4'b0111.
- Pause/resume: drop en after 5 counted cycles and hold low 20 cycles → pos unchanged. After en_s returns high, the step occurs after exactly 3 further cycles.
- Scan check at pos=2: an cycles 1110→1101→1011→0111 every 4 cycles. sseg=7'b0011100 only while an=4'b1101, else 7'h7F.
- Direction flip: toggle cw between steps → the next step uses the new direction. Toggling cw within 2 cycles before a step edge has no effect on that step.
